// File: rtl/rca_ls_request_gather_pkg.sv
// rca_ls_request_gather_pkg: grid sizing, shared LS request record and gather FSM states
package rca_ls_request_gather_pkg;
    localparam int GRID_NUM_ROWS = 4;
    localparam int XLEN = 32;
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            load;
        logic            store;
    } rca_ls_req_t;
    typedef enum logic {COLLECT, PUSH} state_t;
endpackage

// File: rtl/rca_ls_request_gather_if.sv
// rca_ls_request_gather_if: row request side, iteration commit and LSQ packet handshake
interface rca_ls_request_gather_if
    import rca_ls_request_gather_pkg::*;
#(
    parameter int NUM_ROWS = GRID_NUM_ROWS,
    parameter int DATA_W   = XLEN
) ();
    logic                       flush;
    logic [NUM_ROWS-1:0]        row_req;
    logic [NUM_ROWS*DATA_W-1:0] row_addr;
    logic [NUM_ROWS*DATA_W-1:0] row_data;
    logic [NUM_ROWS*3-1:0]      row_fn3;
    logic [NUM_ROWS-1:0]        row_load;
    logic [NUM_ROWS-1:0]        row_store;
    logic [NUM_ROWS-1:0]        row_ack;
    logic                       iter_commit;
    logic                       iter_ready;
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [NUM_ROWS-1:0]        pkt_new_request;
    logic [NUM_ROWS*DATA_W-1:0] pkt_addr;
    logic [NUM_ROWS*DATA_W-1:0] pkt_data;
    logic [NUM_ROWS*3-1:0]      pkt_fn3;
    logic [NUM_ROWS-1:0]        pkt_load;
    logic [NUM_ROWS-1:0]        pkt_store;
    modport slave (
        input  flush, row_req, row_addr, row_data, row_fn3, row_load, row_store,
        input  iter_commit, pkt_ready,
        output row_ack, iter_ready, pkt_valid, pkt_new_request,
        output pkt_addr, pkt_data, pkt_fn3, pkt_load, pkt_store
    );
    modport master (
        output flush, row_req, row_addr, row_data, row_fn3, row_load, row_store,
        output iter_commit, pkt_ready,
        input  row_ack, iter_ready, pkt_valid, pkt_new_request,
        input  pkt_addr, pkt_data, pkt_fn3, pkt_load, pkt_store
    );
endinterface

// File: rtl/rca_ls_request_gather_row_slot.sv
// rca_ls_row_slot: one row's held request; fields are qualified by valid and not reset
module rca_ls_row_slot
    import rca_ls_request_gather_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_capture,
    input  logic        i_clear,
    input  rca_ls_req_t i_req,
    output logic        o_valid,
    output rca_ls_req_t o_req
);
    rca_ls_req_t r_req;
    logic        r_valid;
    // occupancy flag: clear wins, capture only ever happens from an empty slot
    always_ff @(posedge clk or posedge rst)
        if (rst) r_valid <= 1'b0;
        else r_valid <= i_clear ? 1'b0 : (i_capture ? 1'b1 : r_valid);
    // payload register, loaded on capture only
    always_ff @(posedge clk)
        if (i_capture) r_req <= i_req;
    assign o_valid = r_valid;
    assign o_req   = r_req;
endmodule

// File: rtl/rca_ls_request_gather.sv
// rca_ls_request_gather: gathers one LS request per row and pushes them as one packet on commit
// optional perf counters enabled by defining RCA_LS_GATHER_PERF_EN
module rca_ls_request_gather
    import rca_ls_request_gather_pkg::*;
#(
    parameter int NUM_ROWS = GRID_NUM_ROWS,
    parameter int DATA_W   = XLEN,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rca_ls_request_gather_if.slave io
`ifdef RCA_LS_GATHER_PERF_EN
    ,
    output logic [CNT_W-1:0]      o_perf_pkts,
    output logic [CNT_W-1:0]      o_perf_stall_cycles
`endif
);
    state_t              r_state;
    state_t              w_next;
    logic [NUM_ROWS-1:0] w_ack;
    logic [NUM_ROWS-1:0] w_valid;
    logic                w_clear;
    rca_ls_req_t         w_in   [NUM_ROWS];
    rca_ls_req_t         w_slot [NUM_ROWS];

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_slot
        rca_ls_row_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_capture (w_ack[i]),
            .i_clear   (w_clear),
            .i_req     (w_in[i]),
            .o_valid   (w_valid[i]),
            .o_req     (w_slot[i])
        );
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= COLLECT;
        else r_state <= w_next;

    // acks only into empty slots while collecting; flush overrides everything
    always_comb begin
        w_ack   = (r_state == COLLECT && !io.flush && !rst) ? io.row_req & ~w_valid : '0;
        w_next  = io.flush ? COLLECT :
                  (r_state == COLLECT) ? ((io.iter_commit && (|w_valid || |w_ack)) ? PUSH : COLLECT) :
                  (io.pkt_ready ? COLLECT : PUSH);
        w_clear = io.flush || (r_state == PUSH && io.pkt_ready);
    end

    // unpack row inputs into records and repack slot records onto the packet bus
    always_comb begin
        io.pkt_addr  = '0;
        io.pkt_data  = '0;
        io.pkt_fn3   = '0;
        io.pkt_load  = '0;
        io.pkt_store = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            w_in[i] = '{addr:  io.row_addr[i*DATA_W +: DATA_W],
                        data:  io.row_data[i*DATA_W +: DATA_W],
                        fn3:   io.row_fn3[i*3 +: 3],
                        load:  io.row_load[i],
                        store: io.row_store[i]};
            io.pkt_addr[i*DATA_W +: DATA_W] = w_slot[i].addr;
            io.pkt_data[i*DATA_W +: DATA_W] = w_slot[i].data;
            io.pkt_fn3[i*3 +: 3]            = w_slot[i].fn3;
            io.pkt_load[i]                  = w_slot[i].load;
            io.pkt_store[i]                 = w_slot[i].store;
        end
    end

    assign io.row_ack         = w_ack;
    assign io.iter_ready      = (r_state == COLLECT);
    assign io.pkt_valid       = (r_state == PUSH);
    assign io.pkt_new_request = w_valid;

`ifdef RCA_LS_GATHER_PERF_EN
    logic w_hs;
    logic w_stall;
    logic [CNT_W-1:0] r_pkts;
    logic [CNT_W-1:0] r_stall;
    assign w_hs    = (r_state == PUSH) && io.pkt_ready && !io.flush;
    assign w_stall = |(io.row_req & ~w_ack);
    // saturating event counters, cleared by reset only
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pkts  <= '0;
            r_stall <= '0;
        end else begin
            r_pkts  <= (w_hs && !(&r_pkts)) ? r_pkts + 1'b1 : r_pkts;
            r_stall <= (w_stall && !(&r_stall)) ? r_stall + 1'b1 : r_stall;
        end
    assign o_perf_pkts         = r_pkts;
    assign o_perf_stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_rca_ls_request_gather.sv
// tb_rca_ls_request_gather: directed checks of gathering, stalling, holding, flush and reset
module tb_rca_ls_request_gather;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    rca_ls_request_gather_if bus ();
`ifdef RCA_LS_GATHER_PERF_EN
    logic [31:0] perf_pkts;
    logic [31:0] perf_stall;
`endif

    rca_ls_request_gather dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
`ifdef RCA_LS_GATHER_PERF_EN
        ,
        .o_perf_pkts         (perf_pkts),
        .o_perf_stall_cycles (perf_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input int i, input logic [31:0] a, input logic [31:0] d);
        bus.row_req[i] = 1'b1;
        bus.row_addr[i*32 +: 32] = a;
        bus.row_data[i*32 +: 32] = d;
        bus.row_fn3[i*3 +: 3] = 3'(i);
        bus.row_store[i] = 1'b1;
    endtask

    initial begin
        bus.flush = 0; bus.row_req = 0; bus.row_addr = 0; bus.row_data = 0;
        bus.row_fn3 = 0; bus.row_load = 0; bus.row_store = 0;
        bus.iter_commit = 0; bus.pkt_ready = 0;
        tick();
        chk("rst_pkt_valid", 64'(bus.pkt_valid), 0);
        chk("rst_iter_ready", 64'(bus.iter_ready), 1);
        chk("rst_new_req", 64'(bus.pkt_new_request), 0);
        tick();
        rst = 0;
        // two rows request, commit two cycles later
        tick();
        set_row(0, 32'h10, 32'hA0);
        set_row(2, 32'h30, 32'hA2);
        #1;
        chk("t2_ack", 64'(bus.row_ack), 64'b0101);
        tick();
        bus.row_req = 0;
        #1;
        chk("t2_no_pkt_early", 64'(bus.pkt_valid), 0);
        tick();
        bus.iter_commit = 1;
        #1;
        chk("t2_iter_ready", 64'(bus.iter_ready), 1);
        tick();
        bus.iter_commit = 0;
        chk("t2_pkt_valid", 64'(bus.pkt_valid), 1);
        chk("t2_iter_ready_push", 64'(bus.iter_ready), 0);
        chk("t2_new_req", 64'(bus.pkt_new_request), 64'b0101);
        chk("t2_addr0", 64'(bus.pkt_addr[31:0]), 64'h10);
        chk("t2_addr2", 64'(bus.pkt_addr[95:64]), 64'h30);
        chk("t2_data2", 64'(bus.pkt_data[95:64]), 64'hA2);
        chk("t2_fn3_2", 64'(bus.pkt_fn3[8:6]), 64'd2);
        bus.pkt_ready = 1;
        tick();
        bus.pkt_ready = 0;
        chk("t2_pkt_done", 64'(bus.pkt_valid), 0);
        chk("t2_slots_clear", 64'(bus.pkt_new_request), 0);
        // row 1 with a second request behind the first
        set_row(1, 32'h100, 32'hB0);
        #1;
        chk("t3_ack_first", 64'(bus.row_ack), 64'b0010);
        tick();
        set_row(1, 32'h104, 32'hB4);
        bus.iter_commit = 1;
        #1;
        chk("t3_second_held", 64'(bus.row_ack), 0);
        tick();
        bus.iter_commit = 0;
        chk("t3_pkt_valid", 64'(bus.pkt_valid), 1);
        chk("t3_new_req", 64'(bus.pkt_new_request), 64'b0010);
        chk("t3_addr1", 64'(bus.pkt_addr[63:32]), 64'h100);
        // packet held while the LSQ is not ready
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_hold_valid", 64'(bus.pkt_valid), 1);
            chk("t4_hold_addr", 64'(bus.pkt_addr[63:32]), 64'h100);
            chk("t4_hold_new_req", 64'(bus.pkt_new_request), 64'b0010);
            chk("t4_hold_ack", 64'(bus.row_ack), 0);
        end
        bus.pkt_ready = 1;
        tick();
        bus.pkt_ready = 0;
        #1;
        chk("t4_one_hs", 64'(bus.pkt_valid), 0);
        chk("t3_second_acked", 64'(bus.row_ack), 64'b0010);
        tick();
        bus.row_req = 0;
        bus.iter_commit = 1;
        tick();
        bus.iter_commit = 0;
        chk("t3_pkt2_valid", 64'(bus.pkt_valid), 1);
        chk("t3_pkt2_addr", 64'(bus.pkt_addr[63:32]), 64'h104);
        chk("t3_pkt2_data", 64'(bus.pkt_data[63:32]), 64'hB4);
        bus.pkt_ready = 1;
        tick();
        bus.pkt_ready = 0;
        chk("t3_pkt2_done", 64'(bus.pkt_valid), 0);
        tick();
        chk("t3_no_second_pkt", 64'(bus.pkt_valid), 0);
        // empty commit is consumed without a packet
        bus.iter_commit = 1;
        tick();
        bus.iter_commit = 0;
        chk("t5_empty_commit", 64'(bus.pkt_valid), 0);
        chk("t5_iter_ready", 64'(bus.iter_ready), 1);
        tick();
        chk("t5_still_empty", 64'(bus.pkt_valid), 0);
        // same-cycle request and commit
        set_row(3, 32'h300, 32'hC0);
        bus.iter_commit = 1;
        #1;
        chk("t5_ack3", 64'(bus.row_ack), 64'b1000);
        tick();
        bus.iter_commit = 0;
        bus.row_req = 0;
        chk("t5_pkt_valid", 64'(bus.pkt_valid), 1);
        chk("t5_new_req", 64'(bus.pkt_new_request), 64'b1000);
        chk("t5_addr3", 64'(bus.pkt_addr[127:96]), 64'h300);
        // flush with same-cycle commit while pushing
        tick();
        bus.flush = 1;
        bus.iter_commit = 1;
        #1;
        chk("t6_flush_ack", 64'(bus.row_ack), 0);
        tick();
        bus.flush = 0;
        bus.iter_commit = 0;
        chk("t6_pkt_dropped", 64'(bus.pkt_valid), 0);
        chk("t6_slots_clear", 64'(bus.pkt_new_request), 0);
        chk("t6_iter_ready", 64'(bus.iter_ready), 1);
        tick();
        chk("t6_no_pkt", 64'(bus.pkt_valid), 0);
`ifdef RCA_LS_GATHER_PERF_EN
        chk("t6_perf_pkts", 64'(perf_pkts), 64'd3);
`endif
        // flush in collect suppresses ack; request is taken next cycle
        set_row(0, 32'h40, 32'hD0);
        bus.flush = 1;
        #1;
        chk("t6_flush_collect_ack", 64'(bus.row_ack), 0);
        tick();
        bus.flush = 0;
        #1;
        chk("t6_post_flush_ack", 64'(bus.row_ack), 64'b0001);
        tick();
        bus.row_req = 0;
        bus.iter_commit = 1;
        tick();
        bus.iter_commit = 0;
        chk("t1_in_push", 64'(bus.pkt_valid), 1);
        // reset pulse in the middle of a push
        rst = 1;
        bus.row_req = 4'b0010;
        #1;
        chk("t1_rst_pkt_valid", 64'(bus.pkt_valid), 0);
        chk("t1_rst_slots", 64'(bus.pkt_new_request), 0);
        chk("t1_rst_iter_ready", 64'(bus.iter_ready), 1);
        chk("t1_rst_ack", 64'(bus.row_ack), 0);
        tick();
        chk("t1_rst_hold", 64'(bus.pkt_valid), 0);
        rst = 0;
        bus.row_req = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
